adc_frame_receiver: RTL and testbench
=====================================

// Module: adc_frame_receiver
// PURPOSE
//  Reader side of the ADC timing window from the sync controller. On each rising edge of enable_adc:
//   - pulses AD_CONV;
//   - gates 34 SPI clocks;
//   - shifts in the LTC1407A frame on spi_miso;
//   - presents both 14-bit channel samples with a one-cycle valid strobe.
//  Sits between the sync controller and the DAC path / sample consumers.
// PARAMETERS
//  DATA_W      14  sample width per channel
//  FRAME_BITS  34  SCK cycles per conversion frame
//  CH0_OFFSET   2  frame bit index of ch0 MSB (2 Hi-Z bits precede)
//  CH1_OFFSET  18  frame bit index of ch1 MSB
// PORTS
//  clock        in   1       system clock; all state on rising edge
//  reset_n      in   1       asynchronous, active-low reset
//  enable_adc   in   1       ADC window from sync controller (high 35 cycles, low 33)
//  spi_miso     in   1       ADC serial data, MSB first, valid at clock rising edge
//  ad_conv      out  1       conversion start pulse to ADC
//  spi_sck_en   out  1       SCK gate; board top forwards clock to SPI_SCK while high
//  sample_ch0   out  DATA_W  channel 0 sample, held until next good frame
//  sample_ch1   out  DATA_W  channel 1 sample, held until next good frame
//  sample_valid out  1       one-cycle strobe: new samples present
//  frame_error  out  1       one-cycle strobe: frame aborted
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; bit_cnt 0; shift register 0.
//  Edge 0 = first rising clock edge with enable_adc sampled 1 while in IDLE.
//  FSM states and transitions:
//   - IDLE -> CONV at edge 0; ad_conv=1 for exactly one cycle.
//   - CONV -> SHIFT at edge 1; spi_sck_en=1 from edge 1 until edge 35.
//   - SHIFT: spi_miso captured at edges 2..35 into bit_cnt 0..33; bit_cnt increments per edge.
//   - At capture edge bit_cnt==FRAME_BITS-1 (edge 35):
//       sample_ch0 <= frame[2..15]; sample_ch1 <= frame[18..31];
//       sample_valid=1 for one cycle; spi_sck_en=0; -> WAIT_LOW.
//   - WAIT_LOW -> IDLE on first edge with enable_adc=0.
//  Abort rule:
//   - Trigger: enable_adc sampled 0 in CONV, or in SHIFT with bit_cnt != FRAME_BITS-1.
//   - Action: -> IDLE; frame_error=1 for one cycle; ad_conv/spi_sck_en=0; samples unchanged; no sample_valid.
//   - enable_adc is don't-care at the final capture edge: the 35-cycle window ends there.
//  Hi-Z bits (frame 0,1,16,17,32,33) are shifted but discarded.
//  Triggering:
//   - Level high held indefinitely yields exactly one frame; re-arm only via low.
//   - Controller timing gives one frame per 68 cycles.
//  Reset mid-frame: immediate return to reset values; no strobes.
//  Sample format without macro: raw two's complement as delivered by ADC.
// CONFIGURATION
//  ADC_OFFSET_BINARY_EN defined:
//   - MSB of both samples inverted at load (two's complement -> offset binary), feeding unsigned DAC code directly.
//  Undefined: raw two's complement. Timing identical in both builds.
// STRUCTURE
//  Package adc_frame_pkg:
//   - state enum {IDLE, CONV, SHIFT, WAIT_LOW};
//   - FRAME_BITS, CH0_OFFSET, CH1_OFFSET, DATA_W constants.
//  Sub-module adc_frame_shifter:
//   - FRAME_BITS-wide MSB-first shift register with shift enable and clear;
//   - exposes full frame for slicing.
// TESTING
//  1 Reset asserted mid-SHIFT (bit 20) -> all outputs 0 next cycle, no sample_valid/frame_error after release.
//  2 enable_adc rises, MISO frame ch0=14'h2AAA ch1=14'h1555 ->
//    ad_conv high after edge 0 only; spi_sck_en high 34 cycles;
//    sample_valid one cycle after edge 35; samples match.
//  3 enable_adc drops after 12 cycles -> frame_error one pulse, no sample_valid, samples keep prior 14'h2AAA/14'h1555.
//  4 enable_adc held high 200 cycles -> exactly one ad_conv pulse and one sample_valid.
//  5 Controller-style windows (35 high / 33 low) x4, ch0 ramps 0,1,2,3 -> 4 valids, 68 cycles apart, values in order.
//  6 ch0=14'h2000, ch1=14'h1FFF ->
//    with ADC_OFFSET_BINARY_EN: 14'h0000/14'h3FFF;
//    without: 14'h2000/14'h1FFF.

Source files
------------

// File: rtl/adc_frame_pkg.sv
// Shared constants, FSM state type and sample formatting for the ADC frame receiver.
// Build option: ADC_OFFSET_BINARY_EN converts samples to offset binary at load.
package adc_frame_pkg;

  localparam int unsigned DATA_W     = 14;
  localparam int unsigned FRAME_BITS = 34;
  localparam int unsigned CH0_OFFSET = 2;
  localparam int unsigned CH1_OFFSET = 18;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    SHIFT,
    WAIT_LOW
  } state_t;

  function automatic logic [DATA_W-1:0] to_sample(input logic [DATA_W-1:0] raw);
`ifdef ADC_OFFSET_BINARY_EN
    // Flipping the sign bit maps two's complement onto an unsigned DAC code.
    return {~raw[DATA_W-1], raw[DATA_W-2:0]};
`else
    return raw;
`endif
  endfunction

endpackage

// File: rtl/adc_frame_if.sv
// Signal bundle between the sync controller / ADC pins and the frame receiver.
interface adc_frame_if;

  logic                              enable_adc;
  logic                              spi_miso;
  logic                              ad_conv;
  logic                              spi_sck_en;
  logic [adc_frame_pkg::DATA_W-1:0]  sample_ch0;
  logic [adc_frame_pkg::DATA_W-1:0]  sample_ch1;
  logic                              sample_valid;
  logic                              frame_error;

  modport master (
    output enable_adc, spi_miso,
    input  ad_conv, spi_sck_en, sample_ch0, sample_ch1, sample_valid, frame_error
  );

  modport slave (
    input  enable_adc, spi_miso,
    output ad_conv, spi_sck_en, sample_ch0, sample_ch1, sample_valid, frame_error
  );

endinterface

// File: rtl/adc_frame_shifter.sv
// MSB-first serial-in shift register holding one ADC conversion frame.
module adc_frame_shifter
  import adc_frame_pkg::*;
#(
  parameter int unsigned Width = FRAME_BITS
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             din,
  output logic [Width-1:0] frame
);

  logic [Width-1:0] frame_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_q <= '0;
    end else if (clear) begin
      frame_q <= '0;
    end else if (shift_en) begin
      frame_q <= {frame_q[Width-2:0], din};
    end
  end

  assign frame = frame_q;

endmodule

// File: rtl/adc_frame_receiver.sv
// Runs one LTC1407A conversion per enable_adc window: AD_CONV pulse, 34 gated SCKs,
// frame capture and a two-channel sample load. Build option: ADC_OFFSET_BINARY_EN.
module adc_frame_receiver
  import adc_frame_pkg::*;
(
  input logic        clock,
  input logic        reset_n,
  adc_frame_if.slave bus
);

  localparam int unsigned Ch0Msb = FRAME_BITS - 1 - CH0_OFFSET;
  localparam int unsigned Ch1Msb = FRAME_BITS - 1 - CH1_OFFSET;
  localparam logic [CNT_W-1:0] LastBit = CNT_W'(FRAME_BITS - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                ad_conv_q, ad_conv_d;
  logic                sck_en_q, sck_en_d;
  logic                valid_q, valid_d;
  logic                error_q, error_d;
  logic [DATA_W-1:0]   ch0_q, ch0_d;
  logic [DATA_W-1:0]   ch1_q, ch1_d;
  logic                clear;
  logic                shift_en;
  logic [FRAME_BITS-1:0] frame;
  logic [FRAME_BITS-1:0] frame_full;
  logic                unused_frame;

  adc_frame_shifter #(
    .Width (FRAME_BITS)
  ) u_shifter (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (clear),
    .shift_en (shift_en),
    .din      (bus.spi_miso),
    .frame    (frame)
  );

  // The last frame bit arrives on the load edge, so slice the post-shift view.
  assign frame_full   = {frame[FRAME_BITS-2:0], bus.spi_miso};
  assign unused_frame = ^frame_full;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    ad_conv_d = 1'b0;
    sck_en_d  = sck_en_q;
    valid_d   = 1'b0;
    error_d   = 1'b0;
    ch0_d     = ch0_q;
    ch1_d     = ch1_q;
    clear     = 1'b0;
    shift_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.enable_adc) begin
          state_d   = CONV;
          ad_conv_d = 1'b1;
          bit_cnt_d = '0;
          clear     = 1'b1;
        end
      end
      CONV: begin
        if (!bus.enable_adc) begin
          state_d = IDLE;
          error_d = 1'b1;
        end else begin
          state_d  = SHIFT;
          sck_en_d = 1'b1;
        end
      end
      SHIFT: begin
        // The window closes on the final capture edge, so enable_adc is ignored there.
        if (bit_cnt_q == LastBit) begin
          shift_en = 1'b1;
          ch0_d    = to_sample(frame_full[Ch0Msb -: DATA_W]);
          ch1_d    = to_sample(frame_full[Ch1Msb -: DATA_W]);
          valid_d  = 1'b1;
          sck_en_d = 1'b0;
          state_d  = WAIT_LOW;
        end else if (!bus.enable_adc) begin
          sck_en_d = 1'b0;
          error_d  = 1'b1;
          state_d  = IDLE;
        end else begin
          shift_en  = 1'b1;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      WAIT_LOW: begin
        if (!bus.enable_adc) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      ad_conv_q <= 1'b0;
      sck_en_q  <= 1'b0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      ch0_q     <= '0;
      ch1_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      ad_conv_q <= ad_conv_d;
      sck_en_q  <= sck_en_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
      ch0_q     <= ch0_d;
      ch1_q     <= ch1_d;
    end
  end

  assign bus.ad_conv      = ad_conv_q;
  assign bus.spi_sck_en   = sck_en_q;
  assign bus.sample_valid = valid_q;
  assign bus.frame_error  = error_q;
  assign bus.sample_ch0   = ch0_q;
  assign bus.sample_ch1   = ch1_q;

endmodule

// File: tb/tb_adc_frame_receiver.sv
// Randomized self-checking bench for adc_frame_receiver against a window-level timing model.
module tb_adc_frame_receiver;

  logic clock;
  logic reset_n;

  adc_frame_if bus ();

  adc_frame_receiver dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned checks;
  int unsigned failures;
  int          cyc;
  int          last_valid_cyc;
  int          valid_cnt;
  int          conv_cnt;
  logic [13:0] exp_ch0;
  logic [13:0] exp_ch1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [13:0] fmt(input logic [13:0] raw);
`ifdef ADC_OFFSET_BINARY_EN
    return raw ^ 14'h2000;
`else
    return raw;
`endif
  endfunction

  // One enable_adc window: high for hi cycles then low for lo cycles, starting from IDLE.
  task automatic run_window(input logic [13:0] c0, input logic [13:0] c1,
                            input int hi, input int lo);
    logic fb [34];
    logic e_conv, e_sck, e_valid, e_err;
    for (int i = 0; i < 34; i++) begin
      if (i >= 2 && i <= 15)       fb[i] = c0[13-(i-2)];
      else if (i >= 18 && i <= 31) fb[i] = c1[13-(i-18)];
      else                         fb[i] = 1'($urandom);
    end
    for (int c = 0; c < hi + lo; c++) begin
      bus.enable_adc = (c < hi);
      bus.spi_miso   = (c >= 2 && c <= 35) ? fb[c-2] : 1'($urandom);
      @(posedge clock);
      @(negedge clock);
      cyc++;
      e_conv  = (hi >= 1) && (c == 0);
      e_sck   = (hi >= 35) ? (c >= 1 && c <= 34) : (c >= 1 && c <= hi - 1);
      e_valid = (hi >= 35) && (c == 35);
      e_err   = (hi >= 1) && (hi < 35) && (c == hi);
      if (e_valid) begin
        exp_ch0 = fmt(c0);
        exp_ch1 = fmt(c1);
      end
      if (bus.sample_valid) begin
        valid_cnt++;
        last_valid_cyc = cyc;
      end
      if (bus.ad_conv) conv_cnt++;
      check_eq("ad_conv", 32'(bus.ad_conv), 32'(e_conv));
      check_eq("spi_sck_en", 32'(bus.spi_sck_en), 32'(e_sck));
      check_eq("sample_valid", 32'(bus.sample_valid), 32'(e_valid));
      check_eq("frame_error", 32'(bus.frame_error), 32'(e_err));
      check_eq("sample_ch0", 32'(bus.sample_ch0), 32'(exp_ch0));
      check_eq("sample_ch1", 32'(bus.sample_ch1), 32'(exp_ch1));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ad_conv"}, 32'(bus.ad_conv), 32'd0);
    check_eq({tag, "_sck_en"}, 32'(bus.spi_sck_en), 32'd0);
    check_eq({tag, "_valid"}, 32'(bus.sample_valid), 32'd0);
    check_eq({tag, "_error"}, 32'(bus.frame_error), 32'd0);
    check_eq({tag, "_ch0"}, 32'(bus.sample_ch0), 32'd0);
    check_eq({tag, "_ch1"}, 32'(bus.sample_ch1), 32'd0);
  endtask

  initial begin
    int prev_valid, v0, a0, hi, lo;
    checks = 0; failures = 0; cyc = 0; last_valid_cyc = 0; valid_cnt = 0; conv_cnt = 0;
    exp_ch0 = '0; exp_ch1 = '0;
    bus.enable_adc = 1'b0;
    bus.spi_miso   = 1'b0;
    reset_n        = 1'b0;
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clock);

    // Directed frame with alternating bit patterns.
    run_window(14'h2AAA, 14'h1555, 35, 33);

    // Early drop of enable_adc aborts and keeps prior samples.
    run_window(14'h0123, 14'h0456, 12, 10);

    // Reset asserted while bit 20 is being shifted.
    for (int c = 0; c <= 22; c++) begin
      bus.enable_adc = 1'b1;
      bus.spi_miso   = 1'($urandom);
      @(posedge clock);
    end
    @(negedge clock);
    check_eq("mid_frame_sck_en", 32'(bus.spi_sck_en), 32'd1);
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    exp_ch0 = '0;
    exp_ch1 = '0;
    @(negedge clock);
    check_all_zero("mid_reset_held");
    bus.enable_adc = 1'b0;
    reset_n = 1'b1;
    run_window(14'h0, 14'h0, 0, 6);

    // Level held high yields a single frame.
    v0 = valid_cnt;
    a0 = conv_cnt;
    run_window(14'h1234, 14'h2345, 200, 5);
    check_eq("held_conv_count", 32'(conv_cnt - a0), 32'd1);
    check_eq("held_valid_count", 32'(valid_cnt - v0), 32'd1);

    // Controller-paced windows with ramping ch0.
    v0 = valid_cnt;
    for (int k = 0; k < 4; k++) begin
      prev_valid = last_valid_cyc;
      run_window(14'(k), 14'(3 - k), 35, 33);
      if (k > 0) check_eq("ramp_spacing", 32'(last_valid_cyc - prev_valid), 32'd68);
    end
    check_eq("ramp_valid_count", 32'(valid_cnt - v0), 32'd4);

    // Sign-boundary samples.
    run_window(14'h2000, 14'h1FFF, 35, 33);
`ifdef ADC_OFFSET_BINARY_EN
    check_eq("boundary_ch0", 32'(bus.sample_ch0), 32'h0000);
    check_eq("boundary_ch1", 32'(bus.sample_ch1), 32'h3FFF);
`else
    check_eq("boundary_ch0", 32'(bus.sample_ch0), 32'h2000);
    check_eq("boundary_ch1", 32'(bus.sample_ch1), 32'h1FFF);
`endif

    // Random windows, mixing full frames, aborts and long holds.
    for (int k = 0; k < 30; k++) begin
      hi = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 34))
                                       : int'($urandom_range(35, 45));
      lo = int'($urandom_range(2, 40));
      run_window(14'($urandom), 14'($urandom), hi, lo);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
